// File: rtl/demux_pkg.sv
// Shared defaults and ready-path encodings for the 1-to-2 stream demultiplexer.
package demux_pkg;
   localparam int DATA_W_DEF = 4;
   localparam int CNT_W_DEF  = 8;
   localparam int SEL_PASS   = 0;
   localparam int SEL_REG    = 1;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready output; can_load reports the slot is empty.
module demux_slot #(
   parameter int DATA_W = demux_pkg::DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              out_ready,
   output logic              valid,
   output logic [DATA_W-1:0] data_out,
   output logic              can_load
);
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // A load wins over a drain so a simultaneous drain+load keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = data_in;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid    = valid_q;
   assign data_out = data_q;
   assign can_load = !valid_q;
endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-2 stream demux: each beat on Y goes to slot A or B according to sel.
// Optional per-channel drain counters are enabled by defining DEMUX_STREAM_COUNT_EN.
module demux_stream
   import demux_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int SELECT_DESIGN = SEL_PASS,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Y,
   input  logic              y_valid,
   output logic              y_ready,
   input  logic              sel,
   output logic [DATA_W-1:0] A,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] B,
   output logic              b_valid,
   input  logic              b_ready
`ifdef DEMUX_STREAM_COUNT_EN
   ,
   output logic [CNT_W-1:0]  cnt_a,
   output logic [CNT_W-1:0]  cnt_b
`endif
);
   logic a_empty, b_empty;
   logic a_can, b_can;
   logic acc, load_a, load_b;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("demux_stream: CNT_W must be at least 1");
   end

   // Pass-through lets a full slot take a new beat in the cycle it drains;
   // the registered variant only looks at slot state, cutting the ready path.
   if (SELECT_DESIGN == SEL_PASS) begin : g_ready_pass
      assign a_can = a_empty | a_ready;
      assign b_can = b_empty | b_ready;
   end else begin : g_ready_reg
      assign a_can = a_empty;
      assign b_can = b_empty;
   end

   assign y_ready = sel ? b_can : a_can;
   assign acc     = y_valid & y_ready;
   assign load_a  = acc & !sel;
   assign load_b  = acc & sel;

   demux_slot #(.DATA_W(DATA_W)) u_slot_a (
      .clk      (clk),
      .rst      (rst),
      .load     (load_a),
      .data_in  (Y),
      .out_ready(a_ready),
      .valid    (a_valid),
      .data_out (A),
      .can_load (a_empty)
   );

   demux_slot #(.DATA_W(DATA_W)) u_slot_b (
      .clk      (clk),
      .rst      (rst),
      .load     (load_b),
      .data_in  (Y),
      .out_ready(b_ready),
      .valid    (b_valid),
      .data_out (B),
      .can_load (b_empty)
   );

`ifdef DEMUX_STREAM_COUNT_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_valid && a_ready) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (b_valid && b_ready) cnt_b_d = cnt_b_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif
endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: one instance per ready-path design, directed scenarios plus a randomized run against a queue model.
module tb_demux_stream;
   localparam int DW = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] Y = '0;
   logic          y_valid = 1'b0;
   logic          sel = 1'b0;
   logic          a_ready = 1'b0;
   logic          b_ready = 1'b0;

   logic          y_ready0, a_valid0, b_valid0;
   logic [DW-1:0] A0, B0;
   logic          y_ready1, a_valid1, b_valid1;
   logic [DW-1:0] A1, B1;
   logic [CW-1:0] cnt_a0, cnt_b0, cnt_a1, cnt_b1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   demux_stream #(.DATA_W(DW), .SELECT_DESIGN(0), .CNT_W(CW)) dut0 (
      .clk(clk), .rst(rst), .Y(Y), .y_valid(y_valid), .y_ready(y_ready0), .sel(sel),
      .A(A0), .a_valid(a_valid0), .a_ready(a_ready),
      .B(B0), .b_valid(b_valid0), .b_ready(b_ready)
`ifdef DEMUX_STREAM_COUNT_EN
      , .cnt_a(cnt_a0), .cnt_b(cnt_b0)
`endif
   );

   demux_stream #(.DATA_W(DW), .SELECT_DESIGN(1), .CNT_W(CW)) dut1 (
      .clk(clk), .rst(rst), .Y(Y), .y_valid(y_valid), .y_ready(y_ready1), .sel(sel),
      .A(A1), .a_valid(a_valid1), .a_ready(a_ready),
      .B(B1), .b_valid(b_valid1), .b_ready(b_ready)
`ifdef DEMUX_STREAM_COUNT_EN
      , .cnt_a(cnt_a1), .cnt_b(cnt_b1)
`endif
   );

`ifndef DEMUX_STREAM_COUNT_EN
   assign cnt_a0 = '0;
   assign cnt_b0 = '0;
   assign cnt_a1 = '0;
   assign cnt_b1 = '0;
`endif

   // Advance to just after the next rising edge; inputs change here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; y_valid = 1'b0; sel = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; y_valid = 1'b1; Y = 4'd5; sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
      step(); step();
      rst = 1'b0; y_valid = 1'b0;
      #1;
      n_tests++;
      if ({a_valid0, b_valid0, a_valid1, b_valid1} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_valid got %b want 0000", {a_valid0, b_valid0, a_valid1, b_valid1});
      end
      n_tests++;
      if ({A0, B0, A1, B1} !== '0) begin
         n_fail++; $display("FAIL reset_data got %h %h %h %h want 0", A0, B0, A1, B1);
      end
      n_tests++;
      if ({y_ready0, y_ready1} !== 2'b11) begin
         n_fail++; $display("FAIL reset_y_ready got %b want 11", {y_ready0, y_ready1});
      end
      n_tests++;
      if ({cnt_a0, cnt_b0, cnt_a1, cnt_b1} !== '0) begin
         n_fail++; $display("FAIL reset_cnt got %h want 0", {cnt_a0, cnt_b0, cnt_a1, cnt_b1});
      end
   endtask

   task automatic test_pass_throughput();
      do_reset();
      a_ready = 1'b1; sel = 1'b0; y_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         Y = DW'(3 + k);
         #1;
         n_tests++;
         if (y_ready0 !== 1'b1) begin
            n_fail++; $display("FAIL pass_y_ready beat %0d got %b want 1", k, y_ready0);
         end
         step();
         n_tests++;
         if (a_valid0 !== 1'b1 || A0 !== DW'(3 + k)) begin
            n_fail++; $display("FAIL pass_A beat %0d got v=%b A=%0d want v=1 A=%0d", k, a_valid0, A0, 3 + k);
         end
      end
      y_valid = 1'b0;
      step();
      n_tests++;
      if (a_valid0 !== 1'b0) begin
         n_fail++; $display("FAIL pass_drain got a_valid=%b want 0", a_valid0);
      end
   endtask

   task automatic test_reg_throughput();
      do_reset();
      a_ready = 1'b1; sel = 1'b0; y_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         Y = DW'(3 + k / 2);
         #1;
         n_tests++;
         if (y_ready1 !== ((k % 2) == 0)) begin
            n_fail++; $display("FAIL reg_y_ready cycle %0d got %b want %b", k, y_ready1, (k % 2) == 0);
         end
         step();
         n_tests++;
         if ((k % 2) == 0) begin
            if (a_valid1 !== 1'b1 || A1 !== DW'(3 + k / 2)) begin
               n_fail++; $display("FAIL reg_A cycle %0d got v=%b A=%0d want v=1 A=%0d", k, a_valid1, A1, 3 + k / 2);
            end
         end else if (a_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL reg_A cycle %0d got v=%b want v=0", k, a_valid1);
         end
      end
      y_valid = 1'b0;
   endtask

   task automatic test_stall_and_mid_reset();
      do_reset();
      a_ready = 1'b0; b_ready = 1'b1; sel = 1'b0; y_valid = 1'b1; Y = 4'd7;
      step();
      Y = 4'd9;
      #1;
      n_tests++;
      if (y_ready0 !== 1'b0) begin
         n_fail++; $display("FAIL stall_y_ready got %b want 0", y_ready0);
      end
      step();
      n_tests++;
      if (a_valid0 !== 1'b1 || A0 !== 4'd7 || b_valid0 !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold got av=%b A=%0d bv=%b want av=1 A=7 bv=0", a_valid0, A0, b_valid0);
      end
      sel = 1'b1;
      #1;
      n_tests++;
      if (y_ready0 !== 1'b1) begin
         n_fail++; $display("FAIL stall_switch_sel got y_ready=%b want 1", y_ready0);
      end
      step();
      y_valid = 1'b0;
      n_tests++;
      if (b_valid0 !== 1'b1 || B0 !== 4'd9 || A0 !== 4'd7 || a_valid0 !== 1'b1) begin
         n_fail++; $display("FAIL stall_B got bv=%b B=%0d A=%0d av=%b want bv=1 B=9 A=7 av=1", b_valid0, B0, A0, a_valid0);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (a_valid0 !== 1'b0 || b_valid0 !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got av=%b bv=%b want 0 0", a_valid0, b_valid0);
      end
      n_tests++;
      if (cnt_a0 !== '0 || cnt_b0 !== '0) begin
         n_fail++; $display("FAIL mid_reset_cnt got a=%0d b=%0d want 0 0", cnt_a0, cnt_b0);
      end
   endtask

`ifdef DEMUX_STREAM_COUNT_EN
   task automatic test_count_wrap();
      do_reset();
      b_ready = 1'b1; a_ready = 1'b1; sel = 1'b1; y_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         Y = DW'(k);
         step();
      end
      y_valid = 1'b0;
      step(); step();
      n_tests++;
      if (cnt_b0 !== CW'(1) || cnt_a0 !== '0) begin
         n_fail++; $display("FAIL count_wrap got a=%0d b=%0d want a=0 b=1", cnt_a0, cnt_b0);
      end
   endtask
`endif

   // Model: each channel is a queue of depth one; a beat may enter when the
   // target queue is empty, or (pass design) when its head leaves this cycle.
   task automatic test_random();
      logic [DW-1:0] q[2][2][$];
      int cnt[2][2];
      logic          exp_ready;
      logic          got_v[2], got_r;
      logic [DW-1:0] got_d[2];
      logic [CW-1:0] got_c[2];
      logic          pop[2];
      do_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 2; c++) begin
            q[d][c].delete(); cnt[d][c] = 0;
         end
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst     = ($urandom_range(0, 39) == 0);
         y_valid = $urandom_range(0, 3) != 0;
         sel     = $urandom_range(0, 1) == 1;
         Y       = DW'($urandom);
         a_ready = $urandom_range(0, 2) != 0;
         b_ready = $urandom_range(0, 2) != 0;
         #1;
         for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
               got_r = y_ready0; got_v[0] = a_valid0; got_v[1] = b_valid0;
               got_d[0] = A0; got_d[1] = B0; got_c[0] = cnt_a0; got_c[1] = cnt_b0;
            end else begin
               got_r = y_ready1; got_v[0] = a_valid1; got_v[1] = b_valid1;
               got_d[0] = A1; got_d[1] = B1; got_c[0] = cnt_a1; got_c[1] = cnt_b1;
            end
            pop[0] = (q[d][0].size() != 0) && a_ready;
            pop[1] = (q[d][1].size() != 0) && b_ready;
            exp_ready = (q[d][sel].size() == 0) || (d == 0 && pop[sel]);
            n_tests++;
            if (got_r !== exp_ready) begin
               n_fail++; $display("FAIL rnd_y_ready d%0d cyc %0d got %b want %b", d, cyc, got_r, exp_ready);
            end
            for (int c = 0; c < 2; c++) begin
               n_tests++;
               if (got_v[c] !== (q[d][c].size() != 0) ||
                   (q[d][c].size() != 0 && got_d[c] !== q[d][c][0])) begin
                  n_fail++; $display("FAIL rnd_out d%0d ch%0d cyc %0d got v=%b data=%h want v=%b data=%h",
                                     d, c, cyc, got_v[c], got_d[c], q[d][c].size() != 0,
                                     (q[d][c].size() != 0) ? q[d][c][0] : '0);
               end
`ifdef DEMUX_STREAM_COUNT_EN
               n_tests++;
               if (got_c[c] !== CW'(cnt[d][c] % (1 << CW))) begin
                  n_fail++; $display("FAIL rnd_cnt d%0d ch%0d cyc %0d got %0d want %0d",
                                     d, c, cyc, got_c[c], cnt[d][c] % (1 << CW));
               end
`endif
            end
            if (rst) begin
               q[d][0].delete(); q[d][1].delete(); cnt[d][0] = 0; cnt[d][1] = 0;
            end else begin
               for (int c = 0; c < 2; c++)
                  if (pop[c]) begin
                     void'(q[d][c].pop_front()); cnt[d][c]++;
                  end
               if (y_valid && exp_ready) q[d][sel].push_back(Y);
            end
         end
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pass_throughput();
      test_reg_throughput();
      test_stall_and_mid_reset();
`ifdef DEMUX_STREAM_COUNT_EN
      test_count_wrap();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-2 stream demultiplexer, the inverse direction of the team's 2-to-1 mux blocks.
- Accepts one data beat on input Y and steers it to output channel A or B per beat according to sel.
- Each output has a one-entry holding register with a valid/ready handshake.
- Parameter SELECT_DESIGN uses generate-if to pick one of two ready-path implementations.

Parameters:
- DATA_W, 4, width of Y, A and B.
- SELECT_DESIGN, 0, 0 = pass-through ready (full throughput); 1 = registered-style ready (no combinational path from a_ready/b_ready to y_ready).
- CNT_W, 8, width of the transfer counters (only used with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- Y  in  DATA_W  input data beat.
- y_valid  in  1  Y and sel are valid.
- y_ready  out  1  demux accepts the beat this cycle.
- sel  in  1  0 = route to A, 1 = route to B; sampled only on accept.
- A  out  DATA_W  channel A data.
- a_valid  out  1  A holds a beat.
- a_ready  in  1  A consumer accepts.
- B  out  DATA_W  channel B data.
- b_valid  out  1  B holds a beat.
- b_ready  in  1  B consumer accepts.

Behaviour:
- Interface (decided): one clock; clk; rst is synchronous and active-high.
- Reset values: a_valid=0, b_valid=0, A=0, B=0, counters=0. y_ready follows its equation, giving 1 after reset for both designs.
- Input accept: acc = y_valid & y_ready.
- Output drains: drain_a = a_valid & a_ready; drain_b = b_valid & b_ready.
- SELECT_DESIGN=0:
  - y_ready = sel ? (!b_valid | b_ready) : (!a_valid | a_ready).
  - Back-to-back beats to the same channel sustain 1 beat/cycle.
- SELECT_DESIGN=1:
  - y_ready = sel ? !b_valid : !a_valid.
  - Depends only on registered state and sel.
  - Back-to-back beats to the same channel give 1 beat per 2 cycles when the consumer is always ready.
- Per-slot state: each slot is EMPTY (valid=0) or FULL (valid=1).
  - EMPTY→FULL on acc targeting the slot.
  - FULL→EMPTY on drain with no acc targeting the slot.
  - FULL→FULL with new data on simultaneous drain and acc (design 0 only).
  - FULL holds otherwise.
- Latency: beat accepted in cycle n appears on A/B with valid=1 in cycle n+1.
- Data stability: A/B hold their value while valid=1 and ready=0.
- Routing: a beat targeting a full, non-draining slot stalls (y_ready=0) even if the other slot is empty. No reordering, no head-of-line bypass.
- sel is a don't-care when y_valid=0. Changing sel while stalled is legal and re-evaluates y_ready the same cycle.
- Reset mid-operation: held beats are discarded and both valids drop the cycle after rst is high.

Optional Feature:
- Macro: DEMUX_STREAM_COUNT_EN.
- When defined:
  - Adds outputs cnt_a and cnt_b (CNT_W each).
  - Each counter increments on drain_a / drain_b respectively.
  - Wraps 2^CNT_W-1 → 0.
  - Cleared by rst.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package demux_pkg: DATA_W default, CNT_W default, SELECT_DESIGN encodings SEL_PASS=0 and SEL_REG=1.
- Sub-module demux_slot: one-entry holding register with inputs load, data, out_ready and outputs valid, data, can_load. Instantiated twice.
- The generate-if lives in demux_stream and selects the can_load equation.

Test Plan:
- Reset: assert rst 2 cycles with y_valid=1 → a_valid=b_valid=0, A=B=0, y_ready=1 after release.
- Design 0, sel=0, Y=3,4,5 on consecutive cycles, a_ready=1 → A shows 3,4,5 on cycles n+1..n+3; y_ready stays 1.
- Design 1, same stimulus → y_ready toggles 1,0,1,0; A shows 3,4,5 over 6 cycles.
- Stall: a_ready=0, send Y=7 to A, then Y=9 with sel=0 → y_ready=0 and A=7 held. Switch sel=1 → Y=9 accepted, B=9 next cycle.
- Reset mid-operation: A full (A=7), rst pulses 1 cycle → a_valid=0 next cycle; no counter increment.
- With DEMUX_STREAM_COUNT_EN, CNT_W=2: drain 5 beats on B → cnt_b=1 (wrap), cnt_a=0.
